// File: rtl/vyd_wb_hakem_pkg.sv
// Shared VYD types: arbiter state encoding and default bus/requester sizing.
`ifndef ADRES_GENISLIGI_BIT
`define ADRES_GENISLIGI_BIT 32
`endif
`ifndef SOZCUK_GENISLIGI_BIT
`define SOZCUK_GENISLIGI_BIT 32
`endif

package vyd_paket;

  localparam int unsigned VYD_ADRES_GENISLIGI  = `ADRES_GENISLIGI_BIT;
  localparam int unsigned VYD_SOZCUK_GENISLIGI = `SOZCUK_GENISLIGI_BIT;
  localparam int unsigned VYD_ISTEKCI_SAYISI   = 2;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    TAMAM = 2'd2
  } hakem_durum_t;

endpackage

// File: rtl/vyd_wb_hakem_secici.sv
// Combinational winner select; round-robin when VYD_HAKEM_DONER_ONCELIK_EN is
// defined, otherwise fixed priority (lowest index wins).
module vyd_hakem_secici
  import vyd_paket::*;
#(
  parameter int unsigned ISTEKCI_SAYISI   = VYD_ISTEKCI_SAYISI,
  parameter int unsigned SECICI_GENISLIGI = 1
) (
  input  logic [ISTEKCI_SAYISI-1:0]   istek,
  input  logic [SECICI_GENISLIGI-1:0] isaretci,
  output logic                        gecerli,
  output logic [SECICI_GENISLIGI-1:0] secilen
);

`ifdef VYD_HAKEM_DONER_ONCELIK_EN
  int unsigned mesafe;
  int unsigned en_iyi;

  // Nearest requester at or after the pointer, measured with wrap-around.
  always_comb begin
    gecerli = 1'b0;
    secilen = '0;
    mesafe  = 0;
    en_iyi  = ISTEKCI_SAYISI;
    for (int unsigned j = 0; j < ISTEKCI_SAYISI; j++) begin
      if (j >= 32'(isaretci)) mesafe = j - 32'(isaretci);
      else                    mesafe = j + ISTEKCI_SAYISI - 32'(isaretci);
      if (istek[j] && (mesafe < en_iyi)) begin
        en_iyi  = mesafe;
        gecerli = 1'b1;
        secilen = SECICI_GENISLIGI'(j);
      end
    end
  end
`else
  logic unused_isaretci;
  assign unused_isaretci = ^isaretci;

  always_comb begin
    gecerli = 1'b0;
    secilen = '0;
    for (int unsigned j = 0; j < ISTEKCI_SAYISI; j++) begin
      if (istek[j] && !gecerli) begin
        gecerli = 1'b1;
        secilen = SECICI_GENISLIGI'(j);
      end
    end
  end
`endif

endmodule

// File: rtl/vyd_wb_hakem.sv
// Shares one VYD->Wishbone converter among several VYD requesters, one latched
// request at a time. VYD_HAKEM_DONER_ONCELIK_EN selects round-robin arbitration.
module vyd_wb_hakem
  import vyd_paket::*;
#(
  parameter  int unsigned ADRES_GENISLIGI  = `ADRES_GENISLIGI_BIT,
  parameter  int unsigned SOZCUK_GENISLIGI = `SOZCUK_GENISLIGI_BIT,
  parameter  int unsigned ISTEKCI_SAYISI   = VYD_ISTEKCI_SAYISI,
  localparam int unsigned SECICI_GENISLIGI = (ISTEKCI_SAYISI > 1) ? $clog2(ISTEKCI_SAYISI) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [ADRES_GENISLIGI-1:0]  ist_adres_i [0:ISTEKCI_SAYISI-1],
  input  logic [SOZCUK_GENISLIGI-1:0] ist_veri_i  [0:ISTEKCI_SAYISI-1],
  input  logic                        ist_yaz_i   [0:ISTEKCI_SAYISI-1],
  input  logic                        ist_istek_i [0:ISTEKCI_SAYISI-1],
  output logic [SOZCUK_GENISLIGI-1:0] ist_veri_o  [0:ISTEKCI_SAYISI-1],
  output logic                        ist_hazir_o [0:ISTEKCI_SAYISI-1],
  output logic [ADRES_GENISLIGI-1:0]  vyd_adres_o,
  output logic [SOZCUK_GENISLIGI-1:0] vyd_veri_o,
  output logic                        vyd_yaz_o,
  output logic                        vyd_istek_o,
  input  logic [SOZCUK_GENISLIGI-1:0] vyd_veri_i,
  input  logic                        vyd_hazir_i,
  output logic [SECICI_GENISLIGI-1:0] sahip_o
);

  hakem_durum_t                durum_q, durum_d;
  logic [ADRES_GENISLIGI-1:0]  vyd_adres_d;
  logic [SOZCUK_GENISLIGI-1:0] vyd_veri_d;
  logic                        vyd_yaz_d;
  logic                        vyd_istek_d;
  logic [SECICI_GENISLIGI-1:0] sahip_d;
  logic [SOZCUK_GENISLIGI-1:0] ist_veri_d [0:ISTEKCI_SAYISI-1];
  logic [ISTEKCI_SAYISI-1:0]   istek_vek;
  logic [SECICI_GENISLIGI-1:0] isaretci;
  logic                        gecerli;
  logic [SECICI_GENISLIGI-1:0] secilen;

`ifdef VYD_HAKEM_DONER_ONCELIK_EN
  logic [SECICI_GENISLIGI-1:0] isaretci_q, isaretci_d;
  assign isaretci = isaretci_q;
`else
  assign isaretci = '0;
`endif

  always_comb begin
    for (int unsigned j = 0; j < ISTEKCI_SAYISI; j++) istek_vek[j] = ist_istek_i[j];
  end

  vyd_hakem_secici #(
    .ISTEKCI_SAYISI   (ISTEKCI_SAYISI),
    .SECICI_GENISLIGI (SECICI_GENISLIGI)
  ) u_secici (
    .istek    (istek_vek),
    .isaretci (isaretci),
    .gecerli  (gecerli),
    .secilen  (secilen)
  );

  // Next state and next values of every registered output.
  always_comb begin
    durum_d     = durum_q;
    vyd_adres_d = vyd_adres_o;
    vyd_veri_d  = vyd_veri_o;
    vyd_yaz_d   = vyd_yaz_o;
    vyd_istek_d = vyd_istek_o;
    sahip_d     = sahip_o;
    ist_veri_d  = ist_veri_o;
`ifdef VYD_HAKEM_DONER_ONCELIK_EN
    isaretci_d  = isaretci_q;
`endif
    case (durum_q)
      BOSTA: begin
        if (gecerli) begin
          vyd_adres_d = ist_adres_i[secilen];
          vyd_veri_d  = ist_veri_i[secilen];
          vyd_yaz_d   = ist_yaz_i[secilen];
          vyd_istek_d = 1'b1;
          sahip_d     = secilen;
          durum_d     = ISTEK;
`ifdef VYD_HAKEM_DONER_ONCELIK_EN
          isaretci_d  = (32'(secilen) == ISTEKCI_SAYISI - 1) ? '0
                                                             : secilen + SECICI_GENISLIGI'(1);
`endif
        end
      end
      ISTEK: begin
        if (vyd_istek_o && vyd_hazir_i) begin
          ist_veri_d[sahip_o] = vyd_veri_i;
          vyd_istek_d         = 1'b0;
          durum_d             = TAMAM;
        end
      end
      TAMAM:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      vyd_adres_o <= '0;
      vyd_veri_o  <= '0;
      vyd_yaz_o   <= 1'b0;
      vyd_istek_o <= 1'b0;
      sahip_o     <= '0;
      for (int unsigned j = 0; j < ISTEKCI_SAYISI; j++) ist_veri_o[j] <= '0;
    end else begin
      durum_q     <= durum_d;
      vyd_adres_o <= vyd_adres_d;
      vyd_veri_o  <= vyd_veri_d;
      vyd_yaz_o   <= vyd_yaz_d;
      vyd_istek_o <= vyd_istek_d;
      sahip_o     <= sahip_d;
      ist_veri_o  <= ist_veri_d;
    end
  end

`ifdef VYD_HAKEM_DONER_ONCELIK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) isaretci_q <= '0;
    else       isaretci_q <= isaretci_d;
  end
`endif

  // Ready when idle; otherwise a one-cycle completion pulse to the owner.
  always_comb begin
    for (int unsigned j = 0; j < ISTEKCI_SAYISI; j++) begin
      ist_hazir_o[j] = !ist_istek_i[j] ||
                       ((durum_q == TAMAM) && (sahip_o == SECICI_GENISLIGI'(j)));
    end
  end

endmodule
